// File: rtl/fft_ctrl.sv
// fft_ctrl -- address/control sequencer for an in-place radix-2 DIT FFT.
//
// Walks all LOG2N stages over a dual-port sample RAM, issuing one butterfly
// per cycle (two read addresses plus one twiddle-ROM address). It then
// replays each issue as a write-back (wr_en, wr_addr_a, wr_addr_b)
// D = 1 + BF_LATENCY cycles later, so the write lines up with the butterfly
// outputs. A DRAIN gap of D cycles after each stage makes sure the last write
// of a stage lands before the next stage reads. The upstream loader stores
// the input in bit-reversed order, and the results come out in natural order.
//
// Optional feature: define FFT_CTRL_IFFT_EN to add the `inverse` input. It is
// latched at `start` and drives `tw_conj` for the whole run. Without the
// macro, `tw_conj` is tied to 0 and only the forward transform is available.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a transform (sampled only while idle)
//   inverse    request IFFT, sampled with start (FFT_CTRL_IFFT_EN only)
//   busy       transform in progress (RUN and DRAIN)
//   done       one-cycle pulse after the final write
//   stage      current stage index, 0 when not busy
//   rd_addr_a  RAM read address for x1
//   rd_addr_b  RAM read address for x2
//   tw_addr    twiddle ROM address, W_N^t with t = 0..N/2-1
//   wr_en      write y1/y2 back this cycle
//   wr_addr_a  write address for y1
//   wr_addr_b  write address for y2
//   tw_conj    use conj(W) in the butterfly
module fft_ctrl #(
  parameter int  LOG2N      = 8,
  parameter int  BF_LATENCY = 2,
  localparam int SW         = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef FFT_CTRL_IFFT_EN
  input  logic             inverse,
`endif
  output logic             busy,
  output logic             done,
  output logic [SW-1:0]    stage,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b,
  output logic             tw_conj
);

  // Delay from issue to write-back: one cycle of RAM/ROM read, then the
  // butterfly pipeline.
  localparam int D   = 1 + BF_LATENCY;
  localparam int DCW = $clog2(D + 1);
  localparam int JW  = LOG2N - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    stg_q;
  logic [JW-1:0]    j_q;
  logic [DCW-1:0]   dcnt_q;

  logic             last_j;
  logic             last_stage;
  logic             drain_done;

  // Current issue. These values are zero whenever no butterfly is issued.
  logic             iss_vld;
  logic [LOG2N-1:0] iss_a;
  logic [LOG2N-1:0] iss_b;
  logic [LOG2N-2:0] iss_tw;

  // Address arithmetic intermediates.
  logic [JW-1:0]    k_mask;
  logic [JW-1:0]    k;
  logic [SW:0]      sp1;
  logic [SW:0]      tw_sh;
  logic [LOG2N-1:0] base_a;
  logic [LOG2N-1:0] half;

  // Write-back delay line. Entry i holds the issue from i+1 cycles ago.
  logic             vld_p [D];
  logic [LOG2N-1:0] wa_p  [D];
  logic [LOG2N-1:0] wb_p  [D];

  assign last_j     = &j_q;
  assign last_stage = (stg_q == SW'(LOG2N - 1));
  assign drain_done = (dcnt_q == DCW'(D - 1));

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)      state_d = RUN;
      RUN:     if (last_j)     state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = last_stage ? FINISH : RUN;
      FINISH:                  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // ---- stage / butterfly / drain counters ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q  <= '0;
      j_q    <= '0;
      dcnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          stg_q  <= '0;
          j_q    <= '0;
          dcnt_q <= '0;
        end
        RUN: begin
          j_q    <= last_j ? '0 : j_q + 1'b1;
          dcnt_q <= '0;
        end
        DRAIN: begin
          j_q <= '0;
          if (drain_done) begin
            dcnt_q <= '0;
            if (!last_stage) stg_q <= stg_q + 1'b1;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        FINISH: begin
          stg_q  <= '0;
          j_q    <= '0;
          dcnt_q <= '0;
        end
        default: begin
          stg_q  <= '0;
          j_q    <= '0;
          dcnt_q <= '0;
        end
      endcase
    end
  end

  // Butterfly addressing for stage s, butterfly j, half = 2^s:
  //   k = j mod half selects the position inside a group, and the twiddle
  //   index is k scaled up to the full N/2 range.
  //   Group base = (j / half) * 2*half, x1 = base + k, x2 = x1 + half.
  //   Bit s of x1 is always clear, so x2 = x1 | half, which cannot overflow.
  always_comb begin
    k_mask = ~({JW{1'b1}} << stg_q);
    k      = j_q & k_mask;
    sp1    = {1'b0, stg_q} + 1'b1;
    tw_sh  = (SW + 1)'(LOG2N - 1) - {1'b0, stg_q};
    half   = LOG2N'(1) << stg_q;
    base_a = (({1'b0, j_q} >> stg_q) << sp1) | {1'b0, k};
  end

  // ---- output logic ----
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    iss_vld = 1'b0;
    iss_a   = '0;
    iss_b   = '0;
    iss_tw  = '0;
    unique case (state_q)
      IDLE: begin
      end
      RUN: begin
        busy    = 1'b1;
        iss_vld = 1'b1;
        iss_a   = base_a;
        iss_b   = base_a | half;
        iss_tw  = k << tw_sh;
      end
      DRAIN: begin
        busy = 1'b1;
      end
      FINISH: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign stage     = busy ? stg_q : '0;
  assign rd_addr_a = iss_a;
  assign rd_addr_b = iss_b;
  assign tw_addr   = iss_tw;

  // ---- write-back delay line: issue -> RAM/ROM read -> butterfly ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) begin
        vld_p[i] <= 1'b0;
        wa_p[i]  <= '0;
        wb_p[i]  <= '0;
      end
    end else begin
      vld_p[0] <= iss_vld;
      wa_p[0]  <= iss_a;
      wb_p[0]  <= iss_b;
      for (int i = 1; i < D; i++) begin
        vld_p[i] <= vld_p[i-1];
        wa_p[i]  <= wa_p[i-1];
        wb_p[i]  <= wb_p[i-1];
      end
    end
  end

  assign wr_en     = vld_p[D-1];
  assign wr_addr_a = wa_p[D-1];
  assign wr_addr_b = wb_p[D-1];

`ifdef FFT_CTRL_IFFT_EN
  // Direction is captured only when a run is accepted, so toggling
  // `inverse` mid-run has no effect.
  logic inv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      inv_q <= inverse;
    end
  end

  assign tw_conj = inv_q & busy;
`else
  assign tw_conj = 1'b0;
`endif

endmodule
